load_store_unit: RTL and testbench

Multi-cycle data-memory access unit for the 5-stage core. It sits downstream of the memory stage. It takes the stage's load/store request (address, store data, funct3) and runs it on a valid/grant/response data bus. It holds the pipeline via `stall` until the access completes, then returns size-extended load data or an error code.

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit_align.sv | 45 ++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// response error codes and request legality helpers.
package load_store_unit_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FUNCT3   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    // 011 and 11x are never legal; stores have no unsigned variants
    function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: valid/grant request phase followed by a response phase.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables and replicated write data for the
// outgoing request, shift and size extension for returning read data.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic        st_store,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_bus_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    // Per byte lane: enable when the access covers it, data replicated so
    // every lane carries the right byte regardless of alignment
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign st_be[gi] = (st_funct3[1:0] == 2'b00) ? (st_addr_lo == LANE) :
                           (st_funct3[1:0] == 2'b01) ? (st_addr_lo[1] == LANE[1]) :
                           1'b1;
        assign st_bus_wdata[8*gi +: 8] = !st_store                  ? 8'h00 :
                                         (st_funct3[1:0] == 2'b00) ? st_wdata[7:0] :
                                         (st_funct3[1:0] == 2'b01) ? st_wdata[8*(gi%2) +: 8] :
                                         st_wdata[8*gi +: 8];
    end

    assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

    // Extend the addressed byte/halfword to 32 bits per funct3
    always_comb begin
        ld_data = shifted;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ld_data = {24'h0, shifted[7:0]};
            F3_LHU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one memory-stage request, stalls the
// pipeline while it runs on the data bus, then pulses a response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    load_store_unit_if.master bus
);
    lsu_state_e  state_reg, state_next;
    logic [7:0]  cnt_reg;
    logic [7:0]  cnt_inc;
    logic        timeout;
    logic        req_ill, req_mis;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg, bus_wdata_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] resp_rdata_reg;
    lsu_err_e    resp_err_reg;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ld_data;

    assign req_ill = f3_illegal(req_funct3, req_store);
    assign req_mis = addr_misaligned(req_funct3, req_addr[1:0]);
    assign cnt_inc = cnt_reg + 8'd1;
    // Fires on the last allowed bus cycle, so bus_req stays up MAX_WAIT cycles
    assign timeout = (cnt_inc == 8'(MAX_WAIT));

    lsu_align u_align (
        .st_funct3    (req_funct3),
        .st_addr_lo   (req_addr[1:0]),
        .st_store     (req_store),
        .st_wdata     (req_wdata),
        .st_be        (lane_be),
        .st_bus_wdata (lane_wdata),
        .ld_funct3    (funct3_reg),
        .ld_addr_lo   (addr_lo_reg),
        .ld_rdata     (bus.bus_rdata),
        .ld_data      (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state and state-decoded outputs; timeout beats gnt/rvalid
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    stall      = 1'b1;
                    state_next = (req_ill || req_mis) ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                stall = 1'b1;
                if (timeout)          state_next = ST_RESP;
                else if (bus.bus_gnt) state_next = ST_DATA;
            end
            ST_DATA: begin
                stall = 1'b1;
                if (timeout || bus.bus_rvalid) state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, bus output registers, timeout counter and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= 8'd0;
            store_reg      <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_lo_reg    <= 2'b00;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= 32'h0;
            bus_wdata_reg  <= 32'h0;
            bus_be_reg     <= 4'b0000;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= ERR_OK;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        cnt_reg        <= 8'd0;
                        store_reg      <= req_store;
                        funct3_reg     <= req_funct3;
                        addr_lo_reg    <= req_addr[1:0];
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= req_ill ? ERR_FUNCT3 :
                                          req_mis ? ERR_MISALIGN : ERR_OK;
                        if (!req_ill && !req_mis) begin
                            bus_we_reg    <= req_store;
                            bus_addr_reg  <= {req_addr[31:2], 2'b00};
                            bus_wdata_reg <= lane_wdata;
                            bus_be_reg    <= lane_be;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    cnt_reg <= cnt_inc;
                    if (timeout) begin
                        resp_err_reg <= ERR_TIMEOUT;
                    end else if (state_reg == ST_DATA && bus.bus_rvalid) begin
                        resp_rdata_reg <= store_reg ? 32'h0 : ld_data;
                        resp_err_reg   <= ERR_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = (state_reg == ST_ADDR);
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_addr  = bus_addr_reg;
    assign bus.bus_wdata = bus_wdata_reg;
    assign bus.bus_be    = bus_be_reg;
    assign resp_rdata    = resp_rdata_reg;
    assign resp_err      = resp_err_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven bus (MAX_WAIT = 4).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        stall, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int checks = 0;
    int failures = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; bus_ok selects zero-wait bus completion vs. early error
    task automatic access(input string name, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rd,
                          input logic bus_ok, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic [1:0] eerr);
        tick();
        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
        #1;
        chk({name, ".stall0"}, 32'(stall), 32'd1);
        if (bus_ok) begin
            tick();
            bus_if.bus_gnt = 1'b1;
            #1;
            chk({name, ".req"},   32'(bus_if.bus_req), 32'd1);
            chk({name, ".we"},    32'(bus_if.bus_we), 32'(st));
            chk({name, ".addr"},  bus_if.bus_addr, {a[31:2], 2'b00});
            chk({name, ".be"},    32'(bus_if.bus_be), 32'(ebe));
            chk({name, ".wdata"}, bus_if.bus_wdata, ewd);
            chk({name, ".stall1"}, 32'(stall), 32'd1);
            tick();
            bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rd;
            #1;
            chk({name, ".req_drop"}, 32'(bus_if.bus_req), 32'd0);
            chk({name, ".stall2"}, 32'(stall), 32'd1);
            chk({name, ".rv_early"}, 32'(resp_valid), 32'd0);
            tick();
            bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
            #1;
        end else begin
            tick();
            #1;
            chk({name, ".no_req"}, 32'(bus_if.bus_req), 32'd0);
        end
        chk({name, ".resp_valid"}, 32'(resp_valid), 32'd1);
        chk({name, ".stall_resp"}, 32'(stall), 32'd0);
        chk({name, ".rdata"}, resp_rdata, erd);
        chk({name, ".err"}, 32'(resp_err), 32'(eerr));
        $display("TXN %s addr=%h rdata=%h err=%0d", name, a, resp_rdata, resp_err);
        tick();
        req_valid = 1'b0;
        #1;
        chk({name, ".pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int req_cycles;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (3) tick();
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst.bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst.bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst.bus_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst.bus_be", 32'(bus_if.bus_be), 32'h0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.resp_err", 32'(resp_err), 32'h0);
        rst = 1'b0;

        access("LW",   1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00);
        access("LB",   1'b0, 32'h103, 32'h0, 3'b000, 32'h80FFFFFF, 1'b1, 4'b1000, 32'h0, 32'hFFFFFF80, 2'b00);
        access("LBU",  1'b0, 32'h103, 32'h0, 3'b100, 32'h80FFFFFF, 1'b1, 4'b1000, 32'h0, 32'h00000080, 2'b00);
        access("LHU",  1'b0, 32'h102, 32'h0, 3'b101, 32'h80FFFFFF, 1'b1, 4'b1100, 32'h0, 32'h000080FF, 2'b00);
        access("LH",   1'b0, 32'h102, 32'h0, 3'b001, 32'h80FFFFFF, 1'b1, 4'b1100, 32'h0, 32'hFFFF80FF, 2'b00);
        access("LB0",  1'b0, 32'h204, 32'h0, 3'b000, 32'h1234567F, 1'b1, 4'b0001, 32'h0, 32'h0000007F, 2'b00);
        access("SB",   1'b1, 32'h101, 32'h000000AB, 3'b000, 32'h55555555, 1'b1, 4'b0010, 32'hABABABAB, 32'h0, 2'b00);
        access("SH",   1'b1, 32'h102, 32'hFFFF1234, 3'b001, 32'h0, 1'b1, 4'b1100, 32'h12341234, 32'h0, 2'b00);
        access("SW",   1'b1, 32'h104, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 2'b00);
        access("SWmis", 1'b1, 32'h102, 32'h11111111, 3'b010, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 2'b01);
        access("LHmis", 1'b0, 32'h101, 32'h0, 3'b001, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 2'b01);
        access("F3ill", 1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 2'b10);
        access("SBUill", 1'b1, 32'h100, 32'h0, 3'b100, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 2'b10);

        // Timeout: gnt never comes, bus_req must stay up exactly 4 cycles
        tick();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h200; req_funct3 = 3'b010;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (bus_if.bus_req) req_cycles++;
        end
        chk("TO.req_cycles", 32'(req_cycles), 32'd4);
        tick();
        #1;
        chk("TO.req_drop", 32'(bus_if.bus_req), 32'd0);
        chk("TO.resp_valid", 32'(resp_valid), 32'd1);
        chk("TO.err", 32'(resp_err), 32'd3);
        chk("TO.rdata", resp_rdata, 32'h0);
        $display("TXN TO addr=%h rdata=%h err=%0d", req_addr, resp_rdata, resp_err);
        tick();
        req_valid = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h76543210;
        #1;
        chk("TO.late_rv0", 32'(resp_valid), 32'd0);
        tick();
        bus_if.bus_rvalid = 1'b0;
        #1;
        chk("TO.late_rv1", 32'(resp_valid), 32'd0);
        chk("TO.late_stall", 32'(stall), 32'd0);
        chk("TO.late_err", 32'(resp_err), 32'd3);

        // Reset while waiting in DATA
        tick();
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
        tick();
        bus_if.bus_gnt = 1'b1;
        tick();
        bus_if.bus_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("RST.bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("RST.resp_valid", 32'(resp_valid), 32'd0);
        chk("RST.stall", 32'(stall), 32'd0);
        tick();
        #1;
        chk("RST.resp_valid2", 32'(resp_valid), 32'd0);
        $display("TXN RST addr=00000300 aborted");
        access("LWpost", 1'b0, 32'h308, 32'h0, 3'b010, 32'h0BADF00D, 1'b1, 4'b1111, 32'h0, 32'h0BADF00D, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
